// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: control word, NZP codes and writeback mux encodings.
package lc3b_types;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned REG_W  = 3;
    localparam int unsigned NZP_W  = 3;

    typedef logic [WORD_W-1:0] lc3b_word;
    typedef logic [REG_W-1:0]  lc3b_reg;
    typedef logic [NZP_W-1:0]  lc3b_nzp;

    localparam logic [1:0] REGFILEMUX_ALU   = 2'b00;
    localparam logic [1:0] REGFILEMUX_MDR   = 2'b01;
    localparam logic [1:0] REGFILEMUX_PC    = 2'b10;
    localparam logic [1:0] REGFILEMUX_BRADJ = 2'b11;

    localparam lc3b_nzp NZP_Z = 3'b010;

    typedef struct packed {
        logic       load_regfile;
        logic       load_cc;
        logic [1:0] regfilemux_sel;
    } lc3b_control_word;

    // Exactly one of n/z/p is set for any data word.
    function automatic lc3b_nzp gen_nzp(input lc3b_word data);
        logic n;
        logic z;
        n = data[WORD_W-1];
        z = (data == '0);
        return {n, z, ~n & ~z};
    endfunction

endpackage

// File: rtl/lc3b_regfile.sv
// 8x16 register file, one write port, two combinational read ports.
// Same-cycle write-through on the read ports when LC3B_WB_BYPASS_EN is defined.
module lc3b_regfile
    import lc3b_types::*;
#(
    parameter int unsigned REG_COUNT = 8,
    localparam int unsigned ADDR_W = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  lc3b_word          wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output lc3b_word          rdata1,
    output lc3b_word          rdata2
);

    lc3b_word regs [REG_COUNT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

`ifdef LC3B_WB_BYPASS_EN
    always_comb begin
        rdata1 = (we && (raddr1 == waddr)) ? wdata : regs[raddr1];
        rdata2 = (we && (raddr2 == waddr)) ? wdata : regs[raddr2];
    end
`else
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
    end
`endif

endmodule

// File: rtl/lc3b_wb_stage.sv
// LC-3b writeback stage: result select, regfile commit, NZP update and retire count.
// Optional read-port write-through enabled by defining LC3B_WB_BYPASS_EN.
module lc3b_wb_stage
    import lc3b_types::*;
#(
    parameter int unsigned REG_COUNT = 8,
    parameter int unsigned RETIRE_W  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                mem_wb_valid,
    input  lc3b_word            mem_wb_pc_out,
    input  logic [3:0]          mem_wb_opcode_out,
    input  lc3b_word            mem_wb_mdr_out,
    input  lc3b_word            mem_wb_alu_out,
    input  lc3b_word            mem_wb_bradj_out,
    input  lc3b_control_word    mem_wb_ctrl_out,
    input  lc3b_reg             mem_wb_dest_out,
    input  lc3b_reg             sr1,
    input  lc3b_reg             sr2,
    output lc3b_word            sr1_out,
    output lc3b_word            sr2_out,
    output lc3b_nzp             cc_out,
    output lc3b_word            wb_data_out,
    output lc3b_reg             wb_dest_out,
    output logic                wb_regwrite_out,
    output logic [RETIRE_W-1:0] retire_count
);

    logic    commit;
    logic    rf_we;
    lc3b_nzp cc;

    // Opcode travels with the instruction for debug only.
    logic unused_opcode;
    assign unused_opcode = ^mem_wb_opcode_out;

    always_comb begin
        wb_data_out = mem_wb_alu_out;
        unique case (mem_wb_ctrl_out.regfilemux_sel)
            REGFILEMUX_ALU:   wb_data_out = mem_wb_alu_out;
            REGFILEMUX_MDR:   wb_data_out = mem_wb_mdr_out;
            REGFILEMUX_PC:    wb_data_out = mem_wb_pc_out;
            REGFILEMUX_BRADJ: wb_data_out = mem_wb_bradj_out;
            default:          wb_data_out = mem_wb_alu_out;
        endcase
    end

    // Forwarding view ignores load so the hazard unit sees stalled writers too.
    assign wb_dest_out     = mem_wb_dest_out;
    assign wb_regwrite_out = mem_wb_valid & mem_wb_ctrl_out.load_regfile;
    assign commit          = load & mem_wb_valid;
    assign rf_we           = commit & mem_wb_ctrl_out.load_regfile;

    lc3b_regfile #(
        .REG_COUNT (REG_COUNT)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (rf_we),
        .waddr  (mem_wb_dest_out),
        .wdata  (wb_data_out),
        .raddr1 (sr1),
        .raddr2 (sr2),
        .rdata1 (sr1_out),
        .rdata2 (sr2_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cc           <= NZP_Z;
            retire_count <= '0;
        end else if (commit) begin
            if (mem_wb_ctrl_out.load_cc) begin
                cc <= gen_nzp(wb_data_out);
            end
            retire_count <= retire_count + RETIRE_W'(1);
        end
    end

    assign cc_out = cc;

endmodule

// File: tb/tb_lc3b_wb_stage.sv
// Scoreboard bench for lc3b_wb_stage (RETIRE_W=4 so counter wrap is reachable).
module tb_lc3b_wb_stage;
    import lc3b_types::*;

    localparam int unsigned RW = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load;
    logic             mem_wb_valid;
    lc3b_word         mem_wb_pc_out;
    logic [3:0]       mem_wb_opcode_out;
    lc3b_word         mem_wb_mdr_out;
    lc3b_word         mem_wb_alu_out;
    lc3b_word         mem_wb_bradj_out;
    lc3b_control_word mem_wb_ctrl_out;
    lc3b_reg          mem_wb_dest_out;
    lc3b_reg          sr1;
    lc3b_reg          sr2;
    lc3b_word         sr1_out;
    lc3b_word         sr2_out;
    lc3b_nzp          cc_out;
    lc3b_word         wb_data_out;
    lc3b_reg          wb_dest_out;
    logic             wb_regwrite_out;
    logic [RW-1:0]    retire_count;

    lc3b_wb_stage #(.REG_COUNT(8), .RETIRE_W(RW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .load              (load),
        .mem_wb_valid      (mem_wb_valid),
        .mem_wb_pc_out     (mem_wb_pc_out),
        .mem_wb_opcode_out (mem_wb_opcode_out),
        .mem_wb_mdr_out    (mem_wb_mdr_out),
        .mem_wb_alu_out    (mem_wb_alu_out),
        .mem_wb_bradj_out  (mem_wb_bradj_out),
        .mem_wb_ctrl_out   (mem_wb_ctrl_out),
        .mem_wb_dest_out   (mem_wb_dest_out),
        .sr1               (sr1),
        .sr2               (sr2),
        .sr1_out           (sr1_out),
        .sr2_out           (sr2_out),
        .cc_out            (cc_out),
        .wb_data_out       (wb_data_out),
        .wb_dest_out       (wb_dest_out),
        .wb_regwrite_out   (wb_regwrite_out),
        .retire_count      (retire_count)
    );

    always #5 clk = ~clk;

    typedef enum int {K_SR1, K_SR2, K_CC, K_RET, K_DATA, K_RW, K_DEST} kind_e;
    typedef struct {
        int       cycle;
        string    name;
        kind_e    kind;
        logic [15:0] exp;
    } chk_t;

    chk_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation scheduled for the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cycle <= cyc) begin
            chk_t c;
            logic [15:0] act;
            c = q.pop_front();
            case (c.kind)
                K_SR1:  act = sr1_out;
                K_SR2:  act = sr2_out;
                K_CC:   act = 16'(cc_out);
                K_RET:  act = 16'(retire_count);
                K_DATA: act = wb_data_out;
                K_RW:   act = 16'(wb_regwrite_out);
                default: act = 16'(wb_dest_out);
            endcase
            n_tests++;
            if (c.cycle != cyc) begin
                n_fail++;
                $display("FAIL %s: scheduled cycle %0d missed (now %0d)", c.name, c.cycle, cyc);
            end else if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%04h expected 0x%04h", c.name, act, c.exp);
            end
        end
    end

    task automatic expect_now(input string name, input kind_e kind, input logic [15:0] exp);
        chk_t c;
        c.cycle = cyc;
        c.name  = name;
        c.kind  = kind;
        c.exp   = exp;
        q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ld, input logic lrf, input logic lcc,
                         input logic [1:0] sel, input lc3b_word data, input lc3b_reg dest);
        mem_wb_valid      = v;
        load              = ld;
        mem_wb_ctrl_out   = '{load_regfile: lrf, load_cc: lcc, regfilemux_sel: sel};
        mem_wb_alu_out    = 16'hDEAD;
        mem_wb_mdr_out    = 16'hBEEF;
        mem_wb_pc_out     = 16'hCAFE;
        mem_wb_bradj_out  = 16'hF00D;
        case (sel)
            2'b00:   mem_wb_alu_out   = data;
            2'b01:   mem_wb_mdr_out   = data;
            2'b10:   mem_wb_pc_out    = data;
            default: mem_wb_bradj_out = data;
        endcase
        mem_wb_dest_out = dest;
    endtask

    task automatic idle(input lc3b_reg a, input lc3b_reg b);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 3'd0);
        sr1 = a;
        sr2 = b;
    endtask

    task automatic check_all_zero(input string tag);
        for (int r = 0; r < 8; r += 2) begin
            idle(3'(r), 3'(r + 1));
            expect_now({tag, "_rA"}, K_SR1, 16'h0000);
            expect_now({tag, "_rB"}, K_SR2, 16'h0000);
            if (r == 0) begin
                expect_now({tag, "_cc"}, K_CC, 16'(3'b010));
                expect_now({tag, "_ret"}, K_RET, 16'h0000);
            end
            step();
        end
    endtask

    initial begin
        mem_wb_opcode_out = 4'h1;
        sr1 = 3'd0;
        sr2 = 3'd0;
        // Reset with a valid commit pending: no write, no count.
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 16'h8001, 3'd3);
        step();
        rst_n = 1'b1;
        check_all_zero("reset");

        // ALU write, negative result.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 16'h8001, 3'd3);
        expect_now("alu_wbdata", K_DATA, 16'h8001);
        expect_now("alu_regwrite", K_RW, 16'h0001);
        expect_now("alu_dest", K_DEST, 16'h0003);
        step();
        idle(3'd3, 3'd0);
        expect_now("alu_r3", K_SR1, 16'h8001);
        expect_now("alu_cc", K_CC, 16'(3'b100));
        expect_now("alu_ret", K_RET, 16'd1);
        step();

        // Link to R7 (no CC), then zero load to R2, then LEA positive to R4.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 16'h3002, 3'd7);
        expect_now("link_wbdata", K_DATA, 16'h3002);
        step();
        idle(3'd7, 3'd0);
        expect_now("link_cc_kept", K_CC, 16'(3'b100));
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 16'h0000, 3'd2);
        expect_now("mdr_wbdata", K_DATA, 16'h0000);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 16'h0042, 3'd4);
        sr1 = 3'd7;
        sr2 = 3'd2;
        expect_now("link_r7", K_SR1, 16'h3002);
        expect_now("zero_r2", K_SR2, 16'h0000);
        expect_now("zero_cc", K_CC, 16'(3'b010));
        expect_now("zero_ret", K_RET, 16'd3);
        step();
        idle(3'd4, 3'd3);
        expect_now("lea_r4", K_SR1, 16'h0042);
        expect_now("lea_r3_kept", K_SR2, 16'h8001);
        expect_now("lea_cc", K_CC, 16'(3'b001));
        expect_now("lea_ret", K_RET, 16'd4);
        step();

        // Stall: valid instruction held with load=0 for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 16'hA5A5, 3'd6);
            sr1 = 3'd6;
            expect_now("stall_r6", K_SR1, 16'h0000);
            expect_now("stall_ret", K_RET, 16'd4);
            expect_now("stall_regwrite", K_RW, 16'h0001);
            expect_now("stall_cc", K_CC, 16'(3'b001));
            step();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 16'hA5A5, 3'd6);
        step();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 16'hA5A5, 3'd6);
            expect_now("stall_done_r6", K_SR1, 16'hA5A5);
            expect_now("stall_done_ret", K_RET, 16'd5);
            expect_now("stall_done_cc", K_CC, 16'(3'b100));
            step();
        end

        // Bubble: no write, no count, no forwarding write flag.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 16'hFFFF, 3'd1);
        expect_now("bubble_regwrite", K_RW, 16'h0000);
        step();
        idle(3'd1, 3'd0);
        expect_now("bubble_r1", K_SR1, 16'h0000);
        expect_now("bubble_ret", K_RET, 16'd5);
        expect_now("bubble_cc", K_CC, 16'(3'b100));
        step();

        // Same-cycle read of the register being written.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 16'h1111, 3'd5);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 16'h1234, 3'd5);
        sr1 = 3'd5;
`ifdef LC3B_WB_BYPASS_EN
        expect_now("same_cycle_r5", K_SR1, 16'h1234);
`else
        expect_now("same_cycle_r5", K_SR1, 16'h1111);
`endif
        step();
        idle(3'd5, 3'd0);
        expect_now("after_r5", K_SR1, 16'h1234);
        expect_now("after_ret", K_RET, 16'd7);
        step();

        // Counter wrap: 9 more commits takes 7 to 16 == 0 mod 16.
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 16'(i + 1), 3'd0);
            step();
        end
        idle(3'd0, 3'd5);
        expect_now("wrap_ret", K_RET, 16'd0);
        expect_now("wrap_r0", K_SR1, 16'd9);
        step();

        // Reset mid-stream discards the pending instruction.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 16'h8000, 3'd1);
        step();
        idle(3'd1, 3'd0);
        expect_now("pre_rst_ret", K_RET, 16'd1);
        expect_now("pre_rst_cc", K_CC, 16'(3'b100));
        step();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 16'h7777, 3'd6);
        step();
        rst_n = 1'b1;
        check_all_zero("midrst");

        step();
        step();
        done = 1'b1;
    end

    initial begin
        fork
            wait (done);
            begin
                repeat (2000) @(posedge clk);
                n_fail++;
                $display("FAIL watchdog: got timeout expected completion");
            end
        join_any
        disable fork;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3b_wb_stage.md
# lc3b_wb_stage

Writeback stage of the five-stage LC-3b pipeline. It consumes the MEM/WB pipeline register outputs and commits each retiring instruction's architectural effects: it selects the result, writes the 8×16 register file, and updates the NZP condition codes. It also provides the decode-stage register read ports, the forwarding bus for the hazard unit, and a retired-instruction counter.

## Interface
Parameters:
- REG_COUNT, 8, number of general-purpose registers; fixed to 8 for LC-3b.
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- load  in  1  pipeline advance; the same enable as the MEM/WB register. An instruction commits only in a cycle with load=1.
- mem_wb_valid  in  1  1 = real instruction in WB; 0 = bubble.
- mem_wb_pc_out  in  16  PC+2 of the retiring instruction.
- mem_wb_opcode_out  in  4  opcode (informational; not decoded here).
- mem_wb_mdr_out  in  16  load data.
- mem_wb_alu_out  in  16  ALU result.
- mem_wb_bradj_out  in  16  PC-relative adder result.
- mem_wb_ctrl_out  in  lc3b_control_word  provides load_regfile, load_cc, and regfilemux_sel[1:0].
- mem_wb_dest_out  in  3  destination register. R7 is already selected upstream for JSR/TRAP.
- sr1, sr2  in  3 each  decode read addresses.
- sr1_out, sr2_out  out  16 each  decode read data.
- cc_out  out  3  current {n,z,p}.
- wb_data_out  out  16  selected writeback data.
- wb_dest_out  out  3  equals mem_wb_dest_out.
- wb_regwrite_out  out  1  mem_wb_valid & ctrl.load_regfile. Not gated by load; used for forwarding.
- retire_count  out  RETIRE_W  number of committed valid instructions.

## Operation
- Result select by regfilemux_sel:
  - 00: alu_out
  - 01: mdr_out
  - 10: pc_out (link)
  - 11: bradj_out (LEA)
- commit = load & mem_wb_valid.
- Register write: on commit & load_regfile, write regfile[dest] ← wb_data.
- CC update: on commit & load_cc, set cc from wb_data:
  - n = bit15
  - z = (wb_data == 0)
  - p = ~n & ~z
  - Exactly one bit is set at all times.
- CC update is independent of load_regfile; both may occur in the same cycle.
- Retire counter: on commit, retire_count increments by 1 and wraps modulo 2^RETIRE_W without any flag. Bubbles and stalled cycles do not count.
- Stall: while load=0, no regfile, CC, or counter update occurs, even if the held instruction is valid. A stalled instruction therefore commits exactly once.
- Reads: sr1_out and sr2_out are combinational from the regfile (see Configuration for same-cycle write behaviour).

## Timing
- Reset (rst_n=0 at a rising edge):
  - all registers ← 0x0000
  - cc ← 3'b010 (Z)
  - retire_count ← 0
  - Reset has priority over any same-cycle commit.
- Write latency: committed data is visible on read ports from the cycle after the commit edge (0 cycles when bypassed, see Configuration).
- wb_data_out, wb_dest_out, and wb_regwrite_out are purely combinational from the MEM/WB outputs, with no added latency.
- cc_out changes one cycle after the commit edge.
- Reset deasserted mid-stream: the instruction in WB at the reset edge is discarded and not counted.

## Configuration
- LC3B_WB_BYPASS_EN defined:
  - When sr1 or sr2 equals mem_wb_dest_out and commit & load_regfile is true in the same cycle, the read port returns wb_data_out (write-through).
  - The same-cycle write does not need forwarding from the hazard unit.
- Undefined: read ports always return the stored value. A same-cycle read of the register being written returns the old value, and the hazard unit must forward via wb_data_out.

## Structure
- The regfilemux_sel encoding constants and the nzp typedef (lc3b_nzp) belong in lc3b_types alongside lc3b_control_word.
- Sub-module lc3b_regfile holds the 8×16 array with one write port and two read ports, including the bypass logic under the macro. Result mux, CC logic, and counter live in lc3b_wb_stage.

## Test plan
- Reset: rst_n=0 for one edge with a valid commit pending -> all regs 0, cc_out=010, retire_count=0, and no write occurs.
- ALU write: valid=1, load=1, sel=00, alu=0x8001, dest=3, load_regfile=1, load_cc=1 -> R3=0x8001, cc_out=100, retire_count=1.
- Link and zero: sel=10, pc=0x3002, dest=7 -> R7=0x3002. Then sel=01, mdr=0x0000, dest=2, load_cc=1 -> R2=0, cc_out=010.
- Stall: a valid instruction held for 3 cycles with load=0, then load=1 -> exactly one write, and retire_count increments by 1 only on the load=1 cycle.
- Bubble: valid=0, load=1, load_regfile=1, alu=0xFFFF, dest=1 -> R1 unchanged, wb_regwrite_out=0, counter unchanged.
- Same-cycle read: commit writes 0x1234 to R5 while sr1=5 -> sr1_out=0x1234 with LC3B_WB_BYPASS_EN defined, old R5 value without it. Also check counter wrap at RETIRE_W=4: after 16 commits, count=0.
